// File: rtl/hangy_pkg.sv
// Shared types and constants for the hangman front-end: letter code, sequencer states.
package hangy_pkg;

  localparam int unsigned CHAR_WIDTH  = 5;
  localparam int unsigned NUM_LETTERS = 26;
  localparam int unsigned COUNT_WIDTH = 5;

  typedef logic [CHAR_WIDTH-1:0] letter_t;

  localparam letter_t LETTER_LIMIT = CHAR_WIDTH'(NUM_LETTERS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_OFFER   = 2'd2,
    S_RELEASE = 2'd3
  } guess_seq_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus hold counter; the debounced level follows the synced
// input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      // Toggle on the cycle the count would reach DEBOUNCE_CYCLES.
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/guess_sequencer.sv
// Turns debounced button presses into screened guesses (valid/ready) or next pulses.
// Optional repeat-guess bitmap enabled by GUESS_SEQ_DUP_FILTER_EN.
module guess_sequencer
  import hangy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   next_raw,
  input  logic [CHAR_WIDTH-1:0]  char_raw,
  input  logic                   guess_mode,
  input  logic                   new_game,
  output logic                   guess_valid,
  output logic [CHAR_WIDTH-1:0]  guess_char,
  input  logic                   guess_ready,
  output logic                   next_pulse,
  output logic                   invalid_flag,
  output logic                   dup_flag,
  output logic [COUNT_WIDTH-1:0] used_count
);

  logic                   btn_db;
  logic                   btn_db_prev_q;
  logic                   press_c;
  letter_t                char_s1_q, char_s2_q;
  letter_t                char_q, char_d;
  guess_seq_state_t       state_q, state_d;
  logic                   guess_valid_q, guess_valid_d;
  letter_t                guess_char_q, guess_char_d;
  logic                   next_pulse_q, next_pulse_d;
  logic                   invalid_q, invalid_d;
  logic                   dup_q, dup_d;
  logic [COUNT_WIDTH-1:0] used_count_q, used_count_d;
`ifdef GUESS_SEQ_DUP_FILTER_EN
  logic [NUM_LETTERS-1:0] used_q, used_d;
`endif

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next_db (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(next_raw),
    .btn_db (btn_db)
  );

  assign press_c = btn_db & ~btn_db_prev_q;

  always_comb begin
    state_d       = state_q;
    char_d        = char_q;
    guess_valid_d = guess_valid_q;
    guess_char_d  = guess_char_q;
    next_pulse_d  = 1'b0;
    invalid_d     = 1'b0;
    dup_d         = 1'b0;
    used_count_d  = used_count_q;
`ifdef GUESS_SEQ_DUP_FILTER_EN
    used_d        = used_q;
`endif
    // new_game overrides any in-flight transfer, including one completing this cycle.
    if (new_game) begin
      state_d       = S_RELEASE;
      guess_valid_d = 1'b0;
      used_count_d  = '0;
`ifdef GUESS_SEQ_DUP_FILTER_EN
      used_d        = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press_c) begin
            if (guess_mode) begin
              char_d  = char_s2_q;
              state_d = S_CHECK;
            end else begin
              next_pulse_d = 1'b1;
              state_d      = S_RELEASE;
            end
          end
        end
        S_CHECK: begin
          if (char_q >= LETTER_LIMIT) begin
            invalid_d = 1'b1;
            state_d   = S_RELEASE;
          end
`ifdef GUESS_SEQ_DUP_FILTER_EN
          else if (used_q[char_q]) begin
            dup_d   = 1'b1;
            state_d = S_RELEASE;
          end
`endif
          else begin
            guess_valid_d = 1'b1;
            guess_char_d  = char_q;
            state_d       = S_OFFER;
          end
        end
        S_OFFER: begin
          if (guess_valid_q && guess_ready) begin
            guess_valid_d = 1'b0;
            state_d       = S_RELEASE;
`ifdef GUESS_SEQ_DUP_FILTER_EN
            used_d[char_q] = 1'b1;
`endif
            if (used_count_q != COUNT_WIDTH'(NUM_LETTERS)) begin
              used_count_d = used_count_q + COUNT_WIDTH'(1);
            end
          end
        end
        S_RELEASE: begin
          if (!btn_db) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db_prev_q <= 1'b0;
      char_s1_q     <= '0;
      char_s2_q     <= '0;
      char_q        <= '0;
      state_q       <= S_IDLE;
      guess_valid_q <= 1'b0;
      guess_char_q  <= '0;
      next_pulse_q  <= 1'b0;
      invalid_q     <= 1'b0;
      dup_q         <= 1'b0;
      used_count_q  <= '0;
`ifdef GUESS_SEQ_DUP_FILTER_EN
      used_q        <= '0;
`endif
    end else begin
      btn_db_prev_q <= btn_db;
      char_s1_q     <= char_raw;
      char_s2_q     <= char_s1_q;
      char_q        <= char_d;
      state_q       <= state_d;
      guess_valid_q <= guess_valid_d;
      guess_char_q  <= guess_char_d;
      next_pulse_q  <= next_pulse_d;
      invalid_q     <= invalid_d;
      dup_q         <= dup_d;
      used_count_q  <= used_count_d;
`ifdef GUESS_SEQ_DUP_FILTER_EN
      used_q        <= used_d;
`endif
    end
  end

  assign guess_valid  = guess_valid_q;
  assign guess_char   = guess_char_q;
  assign next_pulse   = next_pulse_q;
  assign invalid_flag = invalid_q;
  assign dup_flag     = dup_q;
  assign used_count   = used_count_q;

endmodule
